// File: rtl/sndcmd_fifo.sv
// Sound-board command receiver: synchronises the main-CPU request strobe, queues command bytes,
// and raises one NMI toward the sound Z80 per queued command.
module sndcmd_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NMI_LEN = 32,
  parameter int unsigned NMI_GAP = 16
) (
  input  logic                   CLK48M,
  input  logic                   RESETn,
  input  logic                   SNDRQ,
  input  logic [7:0]             SNDNO,
  input  logic                   SRDSTB,
  input  logic                   SFLUSH,
  output logic [7:0]             SCMD,
  output logic                   SNMI,
  output logic [$clog2(DEPTH):0] SCOUNT,
  output logic                   SOVF
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned TMax = (NMI_LEN > NMI_GAP) ? NMI_LEN : NMI_GAP;
  localparam int unsigned TW   = $clog2(TMax + 1);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAssert, StWaitRd, StGap} nmi_st_e;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          sync3_q, sync3_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    scmd_q, scmd_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  nmi_st_e       state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rd_seen_q, rd_seen_d;

  logic rq_rise;
  logic empty;
  logic full;
  logic pop;
  logic push;

  assign rq_rise = sync2_q & ~sync3_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  assign pop     = SRDSTB & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full queue is still accepted.
  assign push    = rq_rise & (~full | pop);

  always_comb begin
    sync1_d = SNDRQ;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    mem_d   = mem_q;
    scmd_d  = empty ? scmd_q : mem_q[rptr_q];

    if (push) begin
      mem_d[wptr_q] = SNDNO;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (rq_rise && full && !pop) begin
      ovf_d = 1'b1;
    end

    if (SFLUSH) begin
      sync1_d = 1'b0;
      sync2_d = 1'b0;
      sync3_d = 1'b0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      mem_d   = mem_q;
      scmd_d  = scmd_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rd_seen_d = rd_seen_q;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d   = StAssert;
          timer_d   = TW'(NMI_LEN - 1);
          rd_seen_d = 1'b0;
        end
      end
      StAssert: begin
        // The CPU may service the NMI before the pulse ends; remember it for WAITRD.
        if (pop) begin
          rd_seen_d = 1'b1;
        end
        if (timer_q == '0) begin
          state_d = StWaitRd;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StWaitRd: begin
        if (pop || rd_seen_q) begin
          state_d   = StGap;
          timer_d   = TW'(NMI_GAP - 1);
          rd_seen_d = 1'b0;
        end
      end
      StGap: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (SFLUSH) begin
      state_d   = StIdle;
      timer_d   = '0;
      rd_seen_d = 1'b0;
    end
  end

  always_ff @(posedge CLK48M) begin
    if (!RESETn) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      scmd_q    <= 8'h00;
      ovf_q     <= 1'b0;
      state_q   <= StIdle;
      timer_q   <= '0;
      rd_seen_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      scmd_q    <= scmd_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  // Storage needs no reset; it is only observed through count-qualified reads.
  always_ff @(posedge CLK48M) begin
    mem_q <= mem_d;
  end

  assign SCMD   = scmd_q;
  assign SNMI   = (state_q == StAssert);
  assign SCOUNT = count_q;
  assign SOVF   = ovf_q;

endmodule

// File: tb/tb_sndcmd_fifo.sv
// Scoreboard bench for sndcmd_fifo: directed requests, reads checked by a negedge monitor,
// and NMI pulse width/gap tracking.
module tb_sndcmd_fifo;

  localparam int unsigned NmiLen = 32;
  localparam int unsigned NmiGap = 16;

  logic       clk;
  logic       rst_n;
  logic       sndrq;
  logic [7:0] sndno;
  logic       srdstb;
  logic       sflush;
  logic [7:0] scmd;
  logic       snmi;
  logic [2:0] scount;
  logic       sovf;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  int nmi_pulses = 0;
  int hi_len     = 0;
  int lo_len     = 0;
  bit nmi_prev   = 1'b0;
  bit nmi_seen   = 1'b0;
  bit nmi_chk_en = 1'b1;

  sndcmd_fifo #(
    .DEPTH  (4),
    .NMI_LEN(NmiLen),
    .NMI_GAP(NmiGap)
  ) dut (
    .CLK48M(clk),
    .RESETn(rst_n),
    .SNDRQ (sndrq),
    .SNDNO (sndno),
    .SRDSTB(srdstb),
    .SFLUSH(sflush),
    .SCMD  (scmd),
    .SNMI  (snmi),
    .SCOUNT(scount),
    .SOVF  (sovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Read monitor: every strobe on a non-empty queue must present the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && srdstb && !sflush && scount != 3'd0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got 0x%0h expected no entry", scmd);
      end else begin
        exp_b = exp_q.pop_front();
        chk("scmd_read", {24'h0, scmd}, {24'h0, exp_b});
      end
    end
  end

  // NMI monitor: counts pulses, checks width and minimum low time between pulses.
  always @(negedge clk) begin
    if (snmi) begin
      if (!nmi_prev) begin
        nmi_pulses++;
        if (nmi_seen && nmi_chk_en) begin
          total++;
          if (lo_len < NmiGap) begin
            bad++;
            $display("FAIL nmi_gap: got %0d low cycles required >= %0d", lo_len, NmiGap);
          end
        end
        hi_len = 0;
      end
      hi_len++;
    end else begin
      if (nmi_prev) begin
        if (nmi_chk_en) chk("nmi_width", hi_len, NmiLen);
        nmi_seen = 1'b1;
        lo_len   = 0;
      end
      lo_len++;
    end
    nmi_prev = snmi;
  end

  task automatic send(input logic [7:0] b, input bit pop_at_push);
    sndno = b;
    sndrq = 1'b1;
    tick(2);
    if (pop_at_push) srdstb = 1'b1;
    tick(1);
    srdstb = 1'b0;
    tick(13);
    sndrq = 1'b0;
    tick(4);
  endtask

  task automatic rd();
    srdstb = 1'b1;
    tick(1);
    srdstb = 1'b0;
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (!(nmi_pulses >= n && !snmi) && k < 400) begin
      tick(1);
      k++;
    end
    chk("nmi_wait_timeout", (k < 400), 1);
  endtask

  task automatic drain(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      wait_pulses(first + i);
      rd();
    end
  endtask

  initial begin
    sndrq  = 1'b0;
    sndno  = 8'h00;
    srdstb = 1'b0;
    sflush = 1'b0;
    rst_n  = 1'b0;
    tick(3);
    chk("rst_scount", scount, 0);
    chk("rst_scmd", scmd, 8'h00);
    chk("rst_snmi", snmi, 0);
    chk("rst_sovf", sovf, 0);
    rst_n = 1'b1;
    tick(2);

    // Single command with latency checks
    nmi_pulses = 0;
    sndno = 8'h2A;
    sndrq = 1'b1;
    tick(2);
    chk("t1_count_early", scount, 0);
    tick(1);
    chk("t1_count", scount, 1);
    exp_q.push_back(8'h2A);
    tick(1);
    chk("t1_scmd", scmd, 8'h2A);
    chk("t1_snmi_rise", snmi, 1);
    tick(12);
    sndrq = 1'b0;
    tick(4);
    wait_pulses(1);
    rd();
    tick(1);
    chk("t1_count_after_rd", scount, 0);
    chk("t1_scmd_hold", scmd, 8'h2A);
    tick(60);
    chk("t1_pulses", nmi_pulses, 1);
    chk("t1_snmi_low", snmi, 0);

    // Burst of four, one NMI until first read
    nmi_pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send(8'(i), 1'b0);
    end
    chk("t2_count", scount, 4);
    chk("t2_pulses_before_rd", nmi_pulses, 1);
    drain(1, 4);
    tick(60);
    chk("t2_pulses", nmi_pulses, 4);
    chk("t2_count_end", scount, 0);
    chk("t2_scmd_end", scmd, 8'h04);

    // Overflow: fifth byte lost
    nmi_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'h10 + 8'(i));
      send(8'h10 + 8'(i), 1'b0);
    end
    chk("t3_count", scount, 4);
    chk("t3_sovf", sovf, 1);
    drain(1, 4);
    tick(60);
    chk("t3_sovf_sticky", sovf, 1);
    chk("t3_count_end", scount, 0);
    sflush = 1'b1;
    tick(1);
    sflush = 1'b0;
    chk("t3_sovf_flushed", sovf, 0);

    // Push into full queue coinciding with a pop
    nmi_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send(8'h20 + 8'(i), 1'b0);
    end
    chk("t4_count_full", scount, 4);
    exp_q.push_back(8'h24);
    send(8'h24, 1'b1);
    chk("t4_count_simul", scount, 4);
    chk("t4_sovf", sovf, 0);
    drain(2, 4);
    tick(60);
    chk("t4_count_end", scount, 0);
    chk("t4_scmd_end", scmd, 8'h24);

    // Empty read and long level hold
    rd();
    tick(1);
    chk("t5_empty_count", scount, 0);
    chk("t5_empty_scmd", scmd, 8'h24);
    chk("t5_empty_sovf", sovf, 0);
    nmi_pulses = 0;
    sndno = 8'h55;
    sndrq = 1'b1;
    exp_q.push_back(8'h55);
    tick(200);
    chk("t5_level_count", scount, 1);
    sndrq = 1'b0;
    tick(4);
    drain(1, 1);
    tick(60);
    chk("t5_count_end", scount, 0);
    chk("t5_pulses", nmi_pulses, 1);

    // Flush with three queued and NMI high, then reset
    nmi_pulses = 0;
    exp_q.push_back(8'h30);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 1'b0);
    chk("t6_count", scount, 4);
    chk("t6_sovf", sovf, 1);
    drain(1, 1);
    begin
      int k = 0;
      while (!snmi && k < 100) begin
        tick(1);
        k++;
      end
    end
    chk("t6_pre_count", scount, 3);
    chk("t6_pre_snmi", snmi, 1);
    nmi_chk_en = 1'b0;
    sflush = 1'b1;
    tick(1);
    sflush = 1'b0;
    chk("t6_flush_count", scount, 0);
    chk("t6_flush_snmi", snmi, 0);
    chk("t6_flush_sovf", sovf, 0);
    chk("t6_flush_scmd", scmd, 8'h31);
    tick(60);
    chk("t6_pulses", nmi_pulses, 2);
    chk("t6_snmi_low", snmi, 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t6_rst_scmd", scmd, 8'h00);
    chk("t6_rst_count", scount, 0);
    tick(2);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
